// File: rtl/led_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : led_cmd_arbiter
// Brief    : Six-source LED command arbiter (clear priority, round-robin,
//            enforced idle gap after every applied command).
// Revision : 1.0 - initial release
// ============================================================================
module led_cmd_arbiter #(
    parameter int unsigned GAP      = 4,
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] cmd_pulse,
    input  logic       auto_en,
    input  logic [7:0] sw,
    output logic [7:0] led,
    output logic [5:0] grant,
    output logic       busy,
    output logic       dropped
);

    localparam int unsigned      c_TICK_W    = $clog2(TICK_DIV);
    localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(TICK_DIV - 1);
    localparam logic             c_HAS_GAP   = (GAP != 0);
    localparam logic [7:0]       c_GAP_LAST  = c_HAS_GAP ? 8'(GAP - 1) : 8'd0;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_APPLY = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;

    localparam logic [2:0] c_SRC_INV  = 3'd0;
    localparam logic [2:0] c_SRC_LOAD = 3'd1;
    localparam logic [2:0] c_SRC_CLR  = 3'd2;
    localparam logic [2:0] c_SRC_SHL  = 3'd3;
    localparam logic [2:0] c_SRC_SHR  = 3'd4;
    localparam logic [2:0] c_SRC_AUTO = 3'd5;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [5:0]          r_pending;
    logic [5:0]          w_pending_nxt;
    logic [5:0]          w_req;
    logic [2:0]          r_winner;
    logic [2:0]          w_winner;
    logic [2:0]          r_rr;
    logic [7:0]          r_hold;
    logic [c_TICK_W-1:0] r_tick;
    logic                w_tick_wrap;
    logic [7:0]          r_led;
    logic [7:0]          w_led_nxt;
    logic                r_dropped;

    // Round-robin search starting one past the last granted source.
    function automatic logic [2:0] rr_pick(input logic [5:0] pend, input logic [2:0] ptr);
        logic [2:0] pick;
        logic       found;
        int         s;
        pick  = ptr;
        found = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            s = int'(ptr) + k;
            if (s >= 6) s = s - 6;
            if (!found && pend[s]) begin
                pick  = s[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_tick_wrap = auto_en && (r_tick == c_TICK_LAST);
    assign w_req       = {w_tick_wrap, cmd_pulse};
    assign grant       = (r_state == c_ST_APPLY) ? (6'b000001 << r_winner) : 6'b000000;
    assign w_winner    = r_pending[c_SRC_CLR] ? c_SRC_CLR : rr_pick(r_pending, r_rr);

    // New requests are OR-ed in after the grant clear so a same-cycle set survives.
    always_comb begin
        w_pending_nxt = (r_pending & ~grant) | w_req;
        if (!auto_en) w_pending_nxt[c_SRC_AUTO] = 1'b0;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  if (|r_pending) w_state_nxt = c_ST_APPLY;
            c_ST_APPLY: w_state_nxt = c_HAS_GAP ? c_ST_HOLD : c_ST_IDLE;
            c_ST_HOLD:  if (r_hold == c_GAP_LAST) w_state_nxt = c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_led_nxt = r_led;
        case (r_winner)
            c_SRC_INV:  w_led_nxt = ~r_led;
            c_SRC_LOAD: w_led_nxt = sw;
            c_SRC_CLR:  w_led_nxt = 8'h00;
            c_SRC_SHL:  w_led_nxt = {r_led[6:0], 1'b0};
            c_SRC_SHR:  w_led_nxt = {1'b0, r_led[7:1]};
            c_SRC_AUTO: w_led_nxt = {r_led[6:0], r_led[7]};
            default:    w_led_nxt = r_led;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 6'b0;
            r_winner  <= 3'd0;
            r_rr      <= 3'd5;
            r_hold    <= 8'd0;
            r_tick    <= '0;
            r_led     <= 8'h00;
            r_dropped <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_dropped <= |(w_req & r_pending & ~grant);

            if (!auto_en || w_tick_wrap) r_tick <= '0;
            else                         r_tick <= r_tick + c_TICK_W'(1);

            if (r_state == c_ST_IDLE && (|r_pending)) r_winner <= w_winner;

            if (r_state == c_ST_APPLY) begin
                r_led  <= w_led_nxt;
                r_rr   <= r_winner;
                r_hold <= 8'd0;
            end else if (r_state == c_ST_HOLD) begin
                r_hold <= r_hold + 8'd1;
            end
        end
    end

    assign led     = r_led;
    assign busy    = (r_state != c_ST_IDLE);
    assign dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_led_cmd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_led_cmd_arbiter
// Brief    : Scoreboard bench for led_cmd_arbiter (GAP=4, TICK_DIV=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_led_cmd_arbiter;

    typedef struct {
        int         cyc;
        logic [5:0] g;
        logic [7:0] l;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [4:0] cmd_pulse;
    logic       auto_en;
    logic [7:0] sw;
    logic [7:0] led;
    logic [5:0] grant;
    logic       busy;
    logic       dropped;

    exp_t       exp_q[$];
    exp_t       r_e;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;
    logic       mon_led_pend = 1'b0;
    logic [7:0] mon_led_exp = 8'h00;

    led_cmd_arbiter #(
        .GAP      (4),
        .TICK_DIV (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_pulse (cmd_pulse),
        .auto_en   (auto_en),
        .sw        (sw),
        .led       (led),
        .grant     (grant),
        .busy      (busy),
        .dropped   (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, expv, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [5:0] g, input logic [7:0] l);
        exp_t e;
        e.cyc = c;
        e.g   = g;
        e.l   = l;
        exp_q.push_back(e);
    endtask

    task automatic pulse(input logic [4:0] m);
        cmd_pulse = m;
        tick();
        cmd_pulse = 5'b0;
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (exp_q.size() == 0 && !busy && !mon_led_pend) return;
            tick();
        end
        check_eq("drain_timeout", {busy, 31'(exp_q.size())}, 32'd0);
    endtask

    // Grants pop the scoreboard; the led result is compared one cycle later.
    always @(negedge clk) begin
        if (rst) begin
            mon_led_pend = 1'b0;
        end else begin
            if (mon_led_pend) begin
                check_eq("led_after_apply", led, mon_led_exp);
                mon_led_pend = 1'b0;
            end
            if (grant != 6'b0) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_grant", grant, 32'd0);
                end else begin
                    r_e = exp_q.pop_front();
                    check_eq("grant", grant, r_e.g);
                    if (r_e.cyc >= 0) check_eq("grant_cycle", cyc, r_e.cyc);
                    mon_led_exp  = r_e.l;
                    mon_led_pend = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, a, b, m, c, d, e, f;
        rst = 1'b1; cmd_pulse = 5'b0; auto_en = 1'b0; sw = 8'h00;
        repeat (3) tick();
        check_eq("rst_led", led, 8'h00);
        check_eq("rst_grant", grant, 6'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_dropped", dropped, 1'b0);
        check_eq("rst_rr", dut.r_rr, 3'd5);
        rst = 1'b0;
        tick();

        // Load latency and busy window
        sw = 8'hA5; n0 = cyc;
        push(n0 + 2, 6'b000010, 8'hA5);
        pulse(5'b00010);
        check_eq("load_busy_n1", busy, 1'b0);
        for (int k = 2; k <= 7; k++) begin
            tick();
            check_eq("load_busy_window", busy, (k <= 6));
        end
        sw = 8'h00;

        // Auto rotate every 8 cycles, then disabled mid-count
        sw = 8'h80;
        push(cyc + 2, 6'b000010, 8'h80);
        pulse(5'b00010);
        wait_drain(50);
        a = cyc; auto_en = 1'b1;
        push(a + 9,  6'b100000, 8'h01);
        push(a + 17, 6'b100000, 8'h02);
        while (cyc < a + 20) tick();
        auto_en = 1'b0;
        repeat (24) tick();
        check_eq("auto_tick_held", dut.r_tick, 32'd0);
        check_eq("auto_no_more", exp_q.size(), 32'd0);

        // Reach led=81 with rr_ptr=5 via one auto rotate of C0
        sw = 8'hC0;
        push(cyc + 2, 6'b000010, 8'hC0);
        pulse(5'b00010);
        wait_drain(50);
        b = cyc; auto_en = 1'b1;
        push(b + 9, 6'b100000, 8'h81);
        while (cyc < b + 10) tick();
        auto_en = 1'b0;
        wait_drain(50);
        check_eq("rr_after_auto", dut.r_rr, 3'd5);

        // Simultaneous invert/left/right served round-robin
        m = cyc;
        push(m + 2,  6'b000001, 8'h7E);
        push(m + 8,  6'b001000, 8'hFC);
        push(m + 14, 6'b010000, 8'h7E);
        pulse(5'b11001);
        wait_drain(100);

        // Clear beats left even when rr_ptr=2 favours left
        c = cyc;
        push(c + 2, 6'b000100, 8'h00);
        pulse(5'b00100);
        tick(); tick();
        push(c + 8,  6'b000100, 8'h00);
        push(c + 14, 6'b001000, 8'h00);
        pulse(5'b01100);
        while (cyc < c + 9) tick();
        check_eq("rr_after_clear", dut.r_rr, 3'd2);
        wait_drain(100);

        // Merged invert requests during HOLD
        d = cyc;
        push(d + 2, 6'b000001, 8'hFF);
        pulse(5'b00001);
        tick(); tick();
        push(d + 8, 6'b000001, 8'h00);
        cmd_pulse = 5'b00001;
        tick(); check_eq("drop_first_set", dropped, 1'b0);
        tick(); check_eq("drop_merge1", dropped, 1'b1);
        tick(); check_eq("drop_merge2", dropped, 1'b1);
        cmd_pulse = 5'b0;
        tick(); check_eq("drop_idle", dropped, 1'b0);
        wait_drain(100);

        // Reset in HOLD with three sources pending
        e = cyc; sw = 8'h5A;
        push(e + 2, 6'b000010, 8'h5A);
        pulse(5'b00010);
        tick(); tick();
        sw = 8'h00;
        pulse(5'b11001);
        tick();
        rst = 1'b1;
        tick();
        check_eq("hold_rst_led", led, 8'h00);
        check_eq("hold_rst_grant", grant, 6'b0);
        check_eq("hold_rst_busy", busy, 1'b0);
        check_eq("hold_rst_dropped", dropped, 1'b0);
        check_eq("hold_rst_pending", dut.r_pending, 6'b0);
        rst = 1'b0;
        repeat (15) tick();
        check_eq("post_rst_quiet", busy, 1'b0);
        f = cyc;
        push(f + 2, 6'b000001, 8'hFF);
        pulse(5'b00001);
        wait_drain(50);

        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
